// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, ALU control encodings and FSM state type
// for the multi-cycle MIPS-subset control unit.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decoder: ALU operation select plus a legal flag
// covering both unknown opcodes and unknown R-type funct codes.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_control,
  output logic       o_legal
);

  always_comb begin
    o_alu_control = AluAnd;
    o_legal       = 1'b0;
    case (i_opcode)
      OpRtype: begin
        o_legal = 1'b1;
        case (i_funct)
          FunctAdd: o_alu_control = AluAdd;
          FunctSub: o_alu_control = AluSub;
          FunctAnd: o_alu_control = AluAnd;
          FunctOr:  o_alu_control = AluOr;
          FunctSlt: o_alu_control = AluSlt;
          default:  o_legal = 1'b0;
        endcase
      end
      OpLw, OpSw: begin
        o_legal       = 1'b1;
        o_alu_control = AluAdd;
      end
      OpBeq: begin
        o_legal       = 1'b1;
        o_alu_control = AluSub;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for an R-type/lw/sw/beq MIPS subset: latches the
// fetched word, sequences datapath strobes and owns the program counter.
module control_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        Zero,
  output logic [31:0] instruction,
  output logic        ALUScr,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic [3:0]  ALUControl,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal
);

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_instr;

  logic [5:0]  w_opcode;
  logic        w_is_rtype, w_is_lw, w_is_sw, w_is_beq;
  logic [3:0]  w_alu_ctrl;
  logic        w_legal;
  logic        w_active;
  logic [31:0] w_pc_plus4, w_branch_target, w_imm_ext;

  assign w_opcode   = r_instr[31:26];
  assign w_is_rtype = (w_opcode == OpRtype);
  assign w_is_lw    = (w_opcode == OpLw);
  assign w_is_sw    = (w_opcode == OpSw);
  assign w_is_beq   = (w_opcode == OpBeq);

  alu_decoder u_alu_decoder (
    .i_opcode      (w_opcode),
    .i_funct       (r_instr[5:0]),
    .o_alu_control (w_alu_ctrl),
    .o_legal       (w_legal)
  );

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_imm_ext       = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_branch_target = w_pc_plus4 + w_imm_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFetch;
      r_pc    <= PC_RESET;
      r_instr <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (r_state == StFetch && instr_valid) begin
        r_instr <= instr_in;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    instr_ready  = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    retire       = 1'b0;
    illegal      = 1'b0;
    case (r_state)
      StFetch: begin
        instr_ready = 1'b1;
        if (instr_valid) w_state_next = StDecode;
      end
      StDecode: begin
        if (!w_legal) begin
          illegal      = 1'b1;
          w_pc_next    = w_pc_plus4;
          w_state_next = StFetch;
        end else begin
          w_state_next = StExecute;
        end
      end
      StExecute: begin
        if (w_is_beq) begin
          retire       = 1'b1;
          w_pc_next    = Zero ? w_branch_target : w_pc_plus4;
          w_state_next = StFetch;
        end else if (w_is_rtype) begin
          w_state_next = StWriteback;
        end else begin
          w_state_next = StMemory;
        end
      end
      StMemory: begin
        if (w_is_lw) begin
          MemRead      = 1'b1;
          w_state_next = StWriteback;
        end else begin
          MemWrite     = 1'b1;
          retire       = 1'b1;
          w_pc_next    = w_pc_plus4;
          w_state_next = StFetch;
        end
      end
      StWriteback: begin
        RegWrite     = 1'b1;
        retire       = 1'b1;
        w_pc_next    = w_pc_plus4;
        w_state_next = StFetch;
      end
      default: w_state_next = StFetch;
    endcase
  end

  // Static controls derive from the latched word, so they stay put from
  // DECODE until the FSM is back in FETCH; forced low while fetching.
  assign w_active    = (r_state != StFetch) && w_legal;
  assign ALUScr      = w_active && (w_is_lw || w_is_sw);
  assign RegDst      = w_active && w_is_rtype;
  assign MemtoReg    = w_active && w_is_lw;
  assign ALUControl  = w_active ? w_alu_ctrl : 4'b0000;
  assign instruction = r_instr;
  assign pc          = r_pc;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: runs lw/add/beq/illegal/sw-abort/idle
// sequences and compares per-cycle strobes against hand-computed masks.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        Zero;
  logic [31:0] instruction;
  logic        ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg;
  logic [3:0]  ALUControl;
  logic [31:0] pc;
  logic        retire, illegal;

  int n_checks = 0;
  int n_errors = 0;

  // Bit c of each mask holds the signal sampled in cycle c (cycle 1 = FETCH).
  logic [7:0] rec_rw, rec_mr, rec_mw, rec_mtr, rec_ret, rec_ill, rec_rdy, rec_rd, rec_as;
  logic [3:0] rec_alu [8];

  control_unit #(.PC_RESET(32'h00000000)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .Zero        (Zero),
    .instruction (instruction),
    .ALUScr      (ALUScr),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .ALUControl  (ALUControl),
    .pc          (pc),
    .retire      (retire),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction in FETCH and records outputs until retire/illegal,
  // then steps once more so the caller lands back in FETCH.
  task automatic run_instr(input logic [31:0] ins, input logic z);
    logic fin;
    rec_rw = '0; rec_mr = '0; rec_mw = '0; rec_mtr = '0; rec_ret = '0;
    rec_ill = '0; rec_rdy = '0; rec_rd = '0; rec_as = '0;
    for (int i = 0; i < 8; i++) rec_alu[i] = '0;
    instr_in    = ins;
    instr_valid = 1'b1;
    Zero        = z;
    for (int c = 1; c < 8; c++) begin
      rec_rw[c]  = RegWrite;
      rec_mr[c]  = MemRead;
      rec_mw[c]  = MemWrite;
      rec_mtr[c] = MemtoReg;
      rec_ret[c] = retire;
      rec_ill[c] = illegal;
      rec_rdy[c] = instr_ready;
      rec_rd[c]  = RegDst;
      rec_as[c]  = ALUScr;
      rec_alu[c] = ALUControl;
      fin = retire | illegal;
      step();
      instr_valid = 1'b0;
      instr_in    = 32'hDEAD_BEEF;
      if (fin) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic mw_seen, ret_seen;
    logic [31:0] pc_hold;
    rst = 1'b1; instr_in = '0; instr_valid = 1'b0; Zero = 1'b0;
    do_reset();

    // Reset state
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_strobes", {25'b0, ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg, retire},
          32'h0);
    check("rst_alu_ill", {27'b0, ALUControl, illegal}, 32'h0);

    // lw: FETCH, DECODE, EXECUTE, MEMORY(4), WRITEBACK(5)
    run_instr(32'h8C080005, 1'b0);
    check("lw_memread", {24'b0, rec_mr}, 32'h10);
    check("lw_regwrite", {24'b0, rec_rw}, 32'h20);
    check("lw_memtoreg", {24'b0, rec_mtr}, 32'h3C);
    check("lw_alusrc", {24'b0, rec_as}, 32'h3C);
    check("lw_retire", {24'b0, rec_ret}, 32'h20);
    check("lw_memwrite", {24'b0, rec_mw}, 32'h0);
    check("lw_ready", {24'b0, rec_rdy}, 32'h02);
    check("lw_pc", pc, 32'd4);

    // add: WRITEBACK in cycle 4
    run_instr(32'h02324820, 1'b0);
    check("add_aluctl", {28'b0, rec_alu[3]}, 32'h2);
    check("add_regdst", {24'b0, rec_rd}, 32'h1C);
    check("add_alusrc", {24'b0, rec_as}, 32'h0);
    check("add_regwrite", {24'b0, rec_rw}, 32'h10);
    check("add_memwrite", {24'b0, rec_mw}, 32'h0);
    check("add_retire", {24'b0, rec_ret}, 32'h10);
    check("add_pc", pc, 32'd8);

    // beq taken at pc=8: 8+4+(4<<2)=28
    run_instr(32'h110B0004, 1'b1);
    check("beqt_aluctl", {28'b0, rec_alu[2]}, 32'h6);
    check("beqt_strobes", {24'b0, rec_rw | rec_mw | rec_mr}, 32'h0);
    check("beqt_retire", {24'b0, rec_ret}, 32'h08);
    check("beqt_pc", pc, 32'd28);

    // Illegal opcode 111111
    run_instr(32'hFC000000, 1'b0);
    check("ill_pulse", {24'b0, rec_ill}, 32'h04);
    check("ill_strobes", {24'b0, rec_rw | rec_mw | rec_mr | rec_ret}, 32'h0);
    check("ill_pc", pc, 32'd32);
    check("ill_ready", {31'b0, instr_ready}, 32'd1);

    // beq not taken at pc=8
    do_reset();
    run_instr(32'h02324820, 1'b0);
    run_instr(32'h02324820, 1'b0);
    check("beqn_pc_before", pc, 32'd8);
    run_instr(32'h110B0004, 1'b0);
    check("beqn_strobes", {24'b0, rec_rw | rec_mw}, 32'h0);
    check("beqn_pc", pc, 32'd12);

    // sw aborted by reset during EXECUTE
    mw_seen = 1'b0; ret_seen = 1'b0;
    instr_in = 32'hAC09000A; instr_valid = 1'b1;
    mw_seen |= MemWrite;
    step();                       // DECODE
    instr_valid = 1'b0;
    mw_seen |= MemWrite;
    step();                       // EXECUTE
    mw_seen |= MemWrite; ret_seen |= retire;
    check("sw_in_exec_alusrc", {31'b0, ALUScr}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("swrst_pc", pc, 32'h0);
    check("swrst_ready", {31'b0, instr_ready}, 32'd1);
    check("swrst_instr", instruction, 32'h0);
    for (int i = 0; i < 4; i++) begin
      mw_seen |= MemWrite; ret_seen |= retire;
      step();
    end
    check("swrst_no_memwrite", {31'b0, mw_seen}, 32'd0);
    check("swrst_no_retire", {31'b0, ret_seen}, 32'd0);

    // Idle: instr_valid low for 5 cycles
    pc_hold = pc;
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("idle_ready_%0d", i), {31'b0, instr_ready}, 32'd1);
      check($sformatf("idle_strobes_%0d", i),
            {26'b0, RegWrite, MemRead, MemWrite, retire, illegal, ALUScr}, 32'h0);
      step();
    end
    check("idle_pc", pc, pc_hold);
    check("idle_pc_abs", pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port instr_in, input, 32 bits: fetched instruction word.
REQ-005 SHALL have port instr_valid, input, 1 bit: instr_in is valid this cycle.
REQ-006 SHALL have port instr_ready, output, 1 bit: the unit accepts an instruction this cycle.
REQ-007 SHALL have port Zero, input, 1 bit: datapath ALU zero flag.
REQ-008 SHALL have port instruction, output, 32 bits: latched instruction driven to the datapath.
REQ-009 SHALL have ports ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg, each output, 1 bit: datapath controls.
REQ-010 SHALL have port ALUControl, output, 4 bits: ALU operation select.
REQ-011 SHALL have port pc, output, 32 bits: current program counter.
REQ-012 SHALL have ports retire and illegal, each output, 1 bit: one-cycle completion pulse and one-cycle illegal-instruction pulse.

Function
REQ-013 SHALL implement the FSM states FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
REQ-014 SHALL drive instr_ready=1 only in FETCH; on instr_valid&&instr_ready it SHALL latch instr_in into instruction and go to DECODE; otherwise it SHALL hold FETCH.
REQ-015 In DECODE it SHALL decode opcode [31:26] and funct [5:0]: R-type 000000 (funct add 100000, sub 100010, and 100100, or 100101, slt 101010), lw 100011, sw 101011, beq 000100.
REQ-016 SHALL encode ALUControl as and=0000, or=0001, add=0010, sub=0110, slt=0111; lw/sw SHALL use add and beq SHALL use sub.
REQ-017 An illegal opcode or funct SHALL cause DECODE to pulse illegal for 1 cycle, assert no write strobe, set pc+=4 and return to FETCH.
REQ-018 SHALL set ALUScr, RegDst, MemtoReg and ALUControl in DECODE and hold them stable until the return to FETCH: R-type 0/1/0, lw 1/0/1, sw 1/x->0/0, beq 0/0/0.
REQ-019 Path R-type SHALL be FETCH->DECODE->EXECUTE->WRITEBACK->FETCH.
REQ-020 Path lw SHALL be FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK->FETCH.
REQ-021 Path sw SHALL be FETCH->DECODE->EXECUTE->MEMORY->FETCH.
REQ-022 Path beq SHALL be FETCH->DECODE->EXECUTE->FETCH.
REQ-023 RegWrite SHALL be 1 only during WRITEBACK, exactly one cycle.
REQ-024 MemRead SHALL be 1 only in MEMORY for lw; MemWrite SHALL be 1 only in MEMORY for sw, exactly one cycle.
REQ-025 retire SHALL pulse in the last state of each legal instruction; pc SHALL update on that same edge.
REQ-026 SHALL compute next pc as pc+4, except beq with Zero=1 sampled in EXECUTE, which SHALL use pc+4+(sign_extend(instruction[15:0])<<2); the arithmetic is 32-bit and wraps modulo 2^32.
REQ-027 instr_valid SHALL be ignored in every state other than FETCH.

Reset
REQ-028 With rst=1 at a clock edge, the unit SHALL go to FETCH, load PC_RESET into pc, clear instruction to 0, drive every control and pulse output to 0 and ALUControl to 0000; instr_ready SHALL be 1 from the next cycle.
REQ-029 A reset mid-instruction SHALL abort it: no later RegWrite or MemWrite and no retire for that instruction.
REQ-030 rst SHALL take priority over every other input.

Structure
REQ-031 Package mips_pkg SHALL hold the opcode and funct constants, the ALUControl encodings and the state enum typedef.
REQ-032 Sub-module alu_decoder SHALL be combinational and map opcode/funct to ALUControl and a legal flag.

Verification
REQ-033 The bench SHALL check: after reset, lw 32'h8C080005 with valid -> MemRead=1 in cycle 4, RegWrite=1 and MemtoReg=1 in cycle 5, retire in cycle 5, pc 0->4.
REQ-034 The bench SHALL check: add 32'h02324820 -> ALUControl=0010, RegDst=1, ALUScr=0, RegWrite=1 in cycle 4 only, MemWrite never 1.
REQ-035 The bench SHALL check: at pc=8, beq 32'h110B0004 with Zero=1 -> pc=28 after EXECUTE; with Zero=0 -> pc=12; RegWrite and MemWrite stay 0.
REQ-036 The bench SHALL check: opcode 111111 -> illegal pulses 1 cycle in DECODE, no strobes, pc+4, back to FETCH with instr_ready=1.
REQ-037 The bench SHALL check: rst asserted during EXECUTE of sw 32'hAC09000A -> MemWrite never asserted, pc=PC_RESET, state FETCH next cycle.
REQ-038 The bench SHALL check: instr_valid held low for 5 cycles -> state stays FETCH, pc unchanged, all strobes 0.
